// File: rtl/axi_lite_io_slave_pkg.sv
// Shared constants, FSM state types and STATUS packing for the AXI-lite IO slave.
// No logic of its own; imported by every file of the block.
package io_slave_pkg;

  localparam logic [1:0] ADDR_GPIO_OUT = 2'd0;
  localparam logic [1:0] ADDR_GPIO_IN  = 2'd1;
  localparam logic [1:0] ADDR_TX_PUSH  = 2'd2;
  localparam logic [1:0] ADDR_STATUS   = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_CNT_LSB   = 2;
  localparam int STAT_CNT_W     = 5;
  localparam int STAT_OVF_BIT   = 8;

  typedef enum logic {W_IDLE, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  function automatic logic [31:0] pack_status(input logic                  empty,
                                              input logic                  full,
                                              input logic [STAT_CNT_W-1:0] cnt,
                                              input logic                  ovf);
    logic [31:0] s;
    s                              = '0;
    s[STAT_EMPTY_BIT]              = empty;
    s[STAT_FULL_BIT]               = full;
    s[STAT_CNT_LSB +: STAT_CNT_W]  = cnt;
    s[STAT_OVF_BIT]                = ovf;
    return s;
  endfunction

endpackage

// File: rtl/axi_lite_io_slave_if.sv
// AXI4-Lite IO bus bundle (4-bit address, 32-bit data) between core and IO slave.
// Pure wiring; handshakes are plain valid/ready per channel.
interface axi_lite_io_slave_if;

  logic [3:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/axi_lite_io_slave_fifo.sv
// Byte FIFO for the TX stream: 1-cycle push-to-head latency, push ignored when full,
// pop ignored when empty; full is judged on start-of-cycle occupancy.
module io_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o     = (cnt_q == CW'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign count_o    = cnt_q;
  assign head_dat_o = mem_q[rd_ptr_q];
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && !empty_o;

  // DEPTH is a power of two, so pointer overflow is the wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop_ok) cnt_d = cnt_q + CW'(1);
    if (!push_ok && pop_ok) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

endmodule

// File: rtl/axi_lite_io_slave.sv
// AXI4-Lite IO slave: GPIO out/in, TX byte FIFO, STATUS. R and B valid 1 cycle after handshake;
// one transaction in flight per direction, channels stall via ready until the response is taken.
module axi_lite_io_slave
  import io_slave_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  axi_lite_io_slave_if.slave bus,
  input  logic [31:0]        gpio_in_i,
  output logic [31:0]        gpio_out_o,
  output logic [7:0]         tx_data_o,
  output logic               tx_valid_o,
  input  logic               tx_ready_i
);

  localparam int CW = $clog2(DEPTH) + 1;

  wr_state_e   w_state_q, w_state_d;
  rd_state_e   r_state_q, r_state_d;

  logic        aw_cap_q, aw_cap_d;
  logic        w_cap_q, w_cap_d;
  logic [1:0]  aw_idx_q, aw_idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [31:0] gpio_out_q, gpio_out_d;
  logic        ovf_q, ovf_d;
  logic [31:0] sync1_q, sync2_q;
  logic [31:0] rdata_q, rdata_d;

  logic        aw_hs, w_hs, ar_hs;
  logic        wr_commit;
  logic [1:0]  wr_idx;
  logic [31:0] wr_dat;
  logic [3:0]  wr_strb;
  logic        push_req;
  logic        fifo_full, fifo_empty, fifo_pop;
  logic [CW-1:0] fifo_cnt;
  logic [31:0] status_word;
  logic [31:0] rd_mux;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = ^{bus.araddr[1:0], bus.awaddr[1:0]};

  assign aw_hs = bus.awvalid && bus.awready;
  assign w_hs  = bus.wvalid && bus.wready;
  assign ar_hs = bus.arvalid && bus.arready;

  // Second handshake completes the write; the late channel's values are used directly.
  assign wr_commit = (w_state_q == W_IDLE) && (aw_cap_q || aw_hs) && (w_cap_q || w_hs);
  assign wr_idx    = aw_cap_q ? aw_idx_q : bus.awaddr[3:2];
  assign wr_dat    = w_cap_q ? wdata_q : bus.wdata;
  assign wr_strb   = w_cap_q ? wstrb_q : bus.wstrb;
  assign push_req  = wr_commit && (wr_idx == ADDR_TX_PUSH);

  // ---------------- write FSM ----------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) w_state_q <= W_IDLE;
    else          w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (wr_commit) w_state_d = W_RESP;
      W_RESP:  if (bus.bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    bus.awready = (w_state_q == W_IDLE) && !aw_cap_q;
    bus.wready  = (w_state_q == W_IDLE) && !w_cap_q;
    bus.bvalid  = (w_state_q == W_RESP);
    bus.bresp   = bresp_q;
  end

  // ---------------- write datapath ----------------
  always_comb begin
    aw_cap_d   = aw_cap_q;
    w_cap_d    = w_cap_q;
    aw_idx_d   = aw_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    gpio_out_d = gpio_out_q;
    ovf_d      = ovf_q;
    if (aw_hs) begin
      aw_cap_d = 1'b1;
      aw_idx_d = bus.awaddr[3:2];
    end
    if (w_hs) begin
      w_cap_d = 1'b1;
      wdata_d = bus.wdata;
      wstrb_d = bus.wstrb;
    end
    if ((w_state_q == W_RESP) && bus.bready) begin
      aw_cap_d = 1'b0;
      w_cap_d  = 1'b0;
    end
    if (wr_commit) begin
      bresp_d = (push_req && fifo_full) ? RESP_SLVERR : RESP_OKAY;
      if (wr_idx == ADDR_GPIO_OUT) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_strb[b]) gpio_out_d[8*b +: 8] = wr_dat[8*b +: 8];
        end
      end
      if (wr_idx == ADDR_STATUS && wr_dat[STAT_OVF_BIT]) ovf_d = 1'b0;
      if (push_req && fifo_full) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      aw_cap_q   <= 1'b0;
      w_cap_q    <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      gpio_out_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      aw_cap_q   <= aw_cap_d;
      w_cap_q    <= w_cap_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      gpio_out_q <= gpio_out_d;
      ovf_q      <= ovf_d;
    end
  end

  assign gpio_out_o = gpio_out_q;

  // ---------------- GPIO input synchronizer ----------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= gpio_in_i;
      sync2_q <= sync1_q;
    end
  end

  // ---------------- TX FIFO ----------------
  assign fifo_pop = tx_valid_o && tx_ready_i;

  io_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .push_i     (push_req),
    .push_dat_i (wr_dat[7:0]),
    .pop_i      (fifo_pop),
    .head_dat_o (tx_data_o),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_cnt)
  );

  assign tx_valid_o  = !fifo_empty;
  assign status_word = pack_status(fifo_empty, fifo_full, STAT_CNT_W'(fifo_cnt), ovf_q);

  // ---------------- read FSM ----------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) r_state_q <= R_IDLE;
    else          r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_DATA;
      R_DATA:  if (bus.rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    bus.arready = (r_state_q == R_IDLE);
    bus.rvalid  = (r_state_q == R_DATA);
    bus.rresp   = RESP_OKAY;
    bus.rdata   = rdata_q;
  end

  // Sampled from registered state, so a same-edge write is not yet visible.
  always_comb begin
    rd_mux = '0;
    case (bus.araddr[3:2])
      ADDR_GPIO_OUT: rd_mux = gpio_out_q;
      ADDR_GPIO_IN:  rd_mux = sync2_q;
      ADDR_TX_PUSH:  rd_mux = '0;
      ADDR_STATUS:   rd_mux = status_word;
      default:       rd_mux = '0;
    endcase
  end

  assign rdata_d = ar_hs ? rd_mux : rdata_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) rdata_q <= '0;
    else          rdata_q <= rdata_d;
  end

endmodule

// File: tb/tb_axi_lite_io_slave.sv
// Bench for axi_lite_io_slave: directed scenarios then randomized traffic against a
// queue/array model of the register map and TX FIFO.
module tb_axi_lite_io_slave;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int checks   = 0;
  int failures = 0;

  // reference model
  logic [7:0]  m_q[$];
  logic [31:0] m_gpio;
  logic        m_ovf;

  axi_lite_io_slave_if bus ();

  axi_lite_io_slave #(.DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .bus        (bus),
    .gpio_in_i  (gpio_in),
    .gpio_out_o (gpio_out),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    int n;
    n = m_q.size();
    return 32'((n == 0) ? 1 : 0) + 32'((n == DEPTH) ? 2 : 0) + 32'(n * 4) + (m_ovf ? 32'h100 : 32'h0);
  endfunction

  // Called at a negedge; returns at a negedge after the B handshake.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly,
                           output logic [1:0] resp, output logic txv);
    bit aw_pend, w_pend, aw_fire, w_fire;
    int t;
    aw_pend     = 1;
    w_pend      = 1;
    t           = 0;
    bus.awaddr  = addr;
    bus.wdata   = data;
    bus.wstrb   = strb;
    bus.awvalid = (aw_dly == 0);
    bus.wvalid  = (w_dly == 0);
    while ((aw_pend || w_pend) && t < 40) begin
      aw_fire = bus.awvalid && bus.awready;
      w_fire  = bus.wvalid && bus.wready;
      @(posedge clk);
      @(negedge clk);
      t++;
      if (aw_fire) begin aw_pend = 0; bus.awvalid = 1'b0; end
      if (w_fire)  begin w_pend = 0;  bus.wvalid  = 1'b0; end
      if (aw_pend || w_pend) begin
        chk("bvalid_early", bus.bvalid, 0);
        if (aw_pend && t == aw_dly) bus.awvalid = 1'b1;
        if (w_pend && t == w_dly)   bus.wvalid  = 1'b1;
      end
    end
    chk("wr_handshake_timeout", 32'(aw_pend || w_pend), 0);
    chk("bvalid_lat", bus.bvalid, 1);
    resp = bus.bresp;
    txv  = tx_valid;
    @(posedge clk);
    @(negedge clk);
    chk("bvalid_clear", bus.bvalid, 0);
  endtask

  task automatic axi_read(input logic [3:0] addr, input int hold, output logic [31:0] data);
    int t;
    t           = 0;
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    bus.rready  = (hold == 0);
    while (!bus.arready && t < 40) begin
      @(posedge clk);
      @(negedge clk);
      t++;
    end
    chk("rd_arready_timeout", 32'(bus.arready), 1);
    @(posedge clk);
    @(negedge clk);
    bus.arvalid = 1'b0;
    chk("rvalid_lat", bus.rvalid, 1);
    chk("rresp", bus.rresp, 0);
    data = bus.rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rdata_stable", bus.rdata, data);
      chk("rvalid_hold", bus.rvalid, 1);
      chk("arready_low", bus.arready, 0);
    end
    bus.rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rvalid_clear", bus.rvalid, 0);
  endtask

  // Write with the expected outcome taken from the model, then update the model.
  task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, output logic txv);
    logic [1:0] resp, exp_resp;
    exp_resp = 2'b00;
    if (addr[3:2] == 2'd2 && m_q.size() == DEPTH) exp_resp = 2'b10;
    axi_write(addr, data, strb, aw_dly, w_dly, resp, txv);
    chk("bresp", resp, exp_resp);
    case (addr[3:2])
      2'd0: for (int b = 0; b < 4; b++) if (strb[b]) m_gpio[8*b +: 8] = data[8*b +: 8];
      2'd2: if (m_q.size() == DEPTH) m_ovf = 1'b1; else m_q.push_back(data[7:0]);
      2'd3: if (data[8]) m_ovf = 1'b0;
      default: ;
    endcase
    chk("gpio_out", gpio_out, m_gpio);
  endtask

  task automatic drain(input int n);
    tx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (m_q.size() > 0) begin
        chk("tx_valid", tx_valid, 1);
        chk("tx_data", tx_data, m_q[0]);
        @(posedge clk);
        void'(m_q.pop_front());
      end else begin
        chk("tx_valid_empty", tx_valid, 0);
        @(posedge clk);
      end
      @(negedge clk);
    end
    tx_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    m_q.delete();
    m_gpio = '0;
    m_ovf  = 1'b0;
    chk("rst_arready", bus.arready, 1);
    chk("rst_awready", bus.awready, 1);
    chk("rst_wready", bus.wready, 1);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_gpio_out", gpio_out, 0);
    chk("rst_tx_valid", tx_valid, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] rd, rd2;
    logic        txv;
    int          op;

    rst_n       = 1'b0;
    gpio_in     = '0;
    tx_ready    = 1'b0;
    bus.araddr  = '0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    bus.awaddr  = '0;
    bus.awvalid = 1'b0;
    bus.wdata   = '0;
    bus.wstrb   = '0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b1;
    @(negedge clk);
    do_reset();

    axi_read(4'hC, 0, rd);
    chk("status_after_reset", rd, 32'h0000_0001);

    do_write(4'h0, 32'hA5A5_A5A5, 4'b0101, 0, 3, txv);
    chk("gpio_strobe", gpio_out, 32'h00A5_00A5);

    do_write(4'h8, 32'h0000_0011, 4'hF, 0, 0, txv);
    chk("first_push_visible", txv, 1);
    chk("first_push_head", tx_data, 8'h11);
    do_write(4'h8, 32'h0000_0022, 4'h0, 0, 0, txv);
    do_write(4'h8, 32'h0000_0033, 4'hF, 1, 0, txv);
    do_write(4'h8, 32'h0000_0044, 4'hF, 0, 2, txv);
    do_write(4'h8, 32'h0000_0055, 4'hF, 0, 0, txv);
    axi_read(4'hC, 0, rd);
    chk("status_full_ovf", rd, 32'h0000_0112);
    chk("status_full_model", rd, exp_status());

    drain(5);
    do_write(4'hC, 32'h0000_0100, 4'hF, 0, 0, txv);
    axi_read(4'hC, 0, rd);
    chk("status_cleared", rd, 32'h0000_0001);

    gpio_in = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    axi_read(4'h4, 5, rd);
    chk("gpio_in_sync", rd, 32'hDEAD_BEEF);

    fork
      axi_read(4'hC, 0, rd);
      do_write(4'h8, 32'h0000_0077, 4'hF, 0, 0, txv);
    join
    chk("read_pre_write", rd, 32'h0000_0001);
    axi_read(4'hC, 0, rd);
    chk("status_count1", rd, 32'h0000_0004);

    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 6);
      case (op)
        0: do_write({2'd0, 2'($urandom)}, $urandom, 4'($urandom), $urandom_range(0, 2),
                    $urandom_range(0, 2), txv);
        1: do_write({2'd2, 2'($urandom)}, $urandom, 4'($urandom), $urandom_range(0, 2),
                    $urandom_range(0, 2), txv);
        2: begin
          axi_read({2'd3, 2'($urandom)}, $urandom_range(0, 2), rd);
          chk("rand_status", rd, exp_status());
        end
        3: begin
          axi_read({2'd0, 2'($urandom)}, 0, rd);
          chk("rand_gpio_out_rd", rd, m_gpio);
          axi_read({2'd2, 2'($urandom)}, 0, rd2);
          chk("rand_txpush_rd", rd2, 0);
        end
        4: drain($urandom_range(1, 6));
        5: do_write({1'b1, 1'($urandom), 2'($urandom)}, $urandom, 4'($urandom), 0, 0, txv);
        default: begin
          gpio_in = $urandom;
          repeat (2) @(posedge clk);
          @(negedge clk);
          axi_read(4'h4, 0, rd);
          chk("rand_gpio_in", rd, gpio_in);
        end
      endcase
    end

    do_write(4'h0, 32'h1234_5678, 4'hF, 0, 0, txv);
    do_write(4'h8, 32'h0000_00AB, 4'hF, 0, 0, txv);
    do_reset();
    axi_read(4'hC, 0, rd);
    chk("status_after_mid_reset", rd, 32'h0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
